pi_digit_checker: RTL and testbench
===================================

// Module: pi_digit_checker
// PURPOSE
//   Receive-side checker for the pi ASCII digit stream ("31415926535").
//   Samples one ASCII character per digit_valid_i strobe and compares it against an internal table of expected digits.
//   Reports match count, pass/fail, and the first-failure index and character.
//   Sits downstream of the pi digit generator (or a UART RX feeding the same stream) as a self-check and bring-up monitor.
// PARAMETERS
//   NUM_DIGITS      11    digits to check before done_o; legal 1..11
//   TIMEOUT_CYCLES  1024  max clk cycles between accepted digits in CHECK before timeout; >=2
// PORTS
//   clk            in   1  clock; all logic on rising edge
//   rst_n          in   1  reset, asynchronous, active-low
//   start_i        in   1  synchronous re-arm pulse; clears all status, returns to IDLE
//   digit_valid_i  in   1  one-cycle strobe: digit_i valid this cycle
//   digit_i        in   8  ASCII character under test
//   busy_o         out  1  1 in CHECK
//   done_o         out  1  1 in DONE (all NUM_DIGITS matched)
//   pass_o         out  1  equals done_o; 0 in every other state
//   error_o        out  1  1 in ERROR (sticky until start_i or reset)
//   timeout_o      out  1  1 if ERROR was entered by the watchdog
//   err_index_o    out  4  index of the failing position; 0 unless error_o
//   err_char_o     out  8  character received at the failure; 0x00 on timeout or when no error
//   match_count_o  out  4  digits matched so far, 0..NUM_DIGITS
// BEHAVIOUR
//   - Reset: state=IDLE, index=0, wdog=0. All outputs 0.
//   - Expected table (ASCII): idx0..10 = 3,1,4,1,5,9,2,6,5,3,5.
//   - All outputs are registered. A digit sampled at edge N is reflected at the outputs after edge N.
//   - IDLE: no watchdog. On digit_valid_i, compare digit_i with table[0].
//       Match: match_count=1, index=1, go to CHECK (or DONE if NUM_DIGITS==1).
//       Mismatch: go to ERROR, err_index=0, err_char=digit_i.
//   - CHECK: wdog increments on every cycle without digit_valid_i and clears to 0 on each accepted digit.
//       Match at index i: match_count=i+1, index=i+1. When i+1==NUM_DIGITS, go to DONE.
//       Mismatch: go to ERROR, err_index=i, err_char=digit_i. match_count holds.
//       Non-digit characters (e.g. "?") are ordinary mismatches.
//       wdog reaching TIMEOUT_CYCLES-1 with no strobe: go to ERROR next edge with timeout_o=1, err_index=index, err_char=0.
//       A strobe on that same cycle wins: the digit is checked and wdog clears.
//   - DONE: any further digit_valid_i is an overrun. Go to ERROR with err_index=NUM_DIGITS, err_char=digit_i.
//       match_count stays NUM_DIGITS; done_o and pass_o drop.
//   - ERROR: sticky. Strobes are ignored and no status fields change.
//   - start_i (any state): next state IDLE; index, wdog and all status cleared.
//       start_i with a simultaneous digit_valid_i: start wins and the digit is dropped.
//   - rst_n low mid-stream clears immediately (async). Checking resumes from idx0 after release.
//   - index and match_count never exceed NUM_DIGITS. No wrap-around.
// TESTING
//   1 Feed "31415926535" with 1-cycle strobes and arbitrary gaps < TIMEOUT
//     -> done_o=pass_o=1, match_count_o=11, error_o=0.
//   2 Feed "3141" then '6' (0x36)
//     -> error_o=1, err_index_o=4, err_char_o=0x36, match_count_o=4.
//   3 Feed "31", then idle 1024 cycles (TIMEOUT_CYCLES=1024)
//     -> error_o=1, timeout_o=1, err_index_o=2, err_char_o=0x00.
//   4 Complete stream, then strobe '?' (0x3F)
//     -> done_o=0, error_o=1, err_index_o=11, err_char_o=0x3F, match_count_o=11.
//   5 Feed "314", then pulse start_i together with a strobe, then a full stream
//     -> status clears, the colliding digit is ignored, done_o=1.
//   6 Assert rst_n low mid-edge after 5 digits, release, then a full stream
//     -> outputs 0 during reset; pass_o=1 at the end.

Source files
------------

// File: rtl/pi_digit_checker.sv
// Receive-side checker for the ASCII pi digit stream "31415926535".
// Compares each strobed character against a fixed table and latches the first failure.
module pi_digit_checker #(
  parameter int NUM_DIGITS     = 11,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_i,
  input  logic       digit_valid_i,
  input  logic [7:0] digit_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       pass_o,
  output logic       error_o,
  output logic       timeout_o,
  output logic [3:0] err_index_o,
  output logic [7:0] err_char_o,
  output logic [3:0] match_count_o,
  output logic [1:0] dbg_state
);

  localparam int WW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [WW-1:0] WDOG_LAST = WW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]    LAST_IDX  = 4'(NUM_DIGITS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    DONE  = 2'd2,
    ERROR = 2'd3
  } state_t;

  state_t        state;
  logic [3:0]    index;
  logic [WW-1:0] wdog;
  logic [3:0]    next_idx;

  assign next_idx  = index + 4'd1;
  assign dbg_state = state;

  function automatic logic [7:0] expected_char(input logic [3:0] i);
    case (i)
      4'd0, 4'd9:        expected_char = 8'h33;
      4'd1, 4'd3:        expected_char = 8'h31;
      4'd2:              expected_char = 8'h34;
      4'd4, 4'd8, 4'd10: expected_char = 8'h35;
      4'd5:              expected_char = 8'h39;
      4'd6:              expected_char = 8'h32;
      4'd7:              expected_char = 8'h36;
      default:           expected_char = 8'h00;
    endcase
  endfunction

  // Status flags are registered alongside the state so every output is a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      index         <= '0;
      wdog          <= '0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      pass_o        <= 1'b0;
      error_o       <= 1'b0;
      timeout_o     <= 1'b0;
      err_index_o   <= '0;
      err_char_o    <= '0;
      match_count_o <= '0;
    end else if (start_i) begin
      state         <= IDLE;
      index         <= '0;
      wdog          <= '0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      pass_o        <= 1'b0;
      error_o       <= 1'b0;
      timeout_o     <= 1'b0;
      err_index_o   <= '0;
      err_char_o    <= '0;
      match_count_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (digit_valid_i) begin
            if (digit_i == expected_char(4'd0)) begin
              index         <= 4'd1;
              match_count_o <= 4'd1;
              wdog          <= '0;
              if (LAST_IDX == 4'd1) begin
                state  <= DONE;
                done_o <= 1'b1;
                pass_o <= 1'b1;
              end else begin
                state  <= CHECK;
                busy_o <= 1'b1;
              end
            end else begin
              state       <= ERROR;
              error_o     <= 1'b1;
              err_index_o <= 4'd0;
              err_char_o  <= digit_i;
            end
          end
        end
        CHECK: begin
          // A strobe arriving on the last watchdog cycle still counts as in time.
          if (digit_valid_i) begin
            wdog <= '0;
            if (digit_i == expected_char(index)) begin
              index         <= next_idx;
              match_count_o <= next_idx;
              if (next_idx == LAST_IDX) begin
                state  <= DONE;
                busy_o <= 1'b0;
                done_o <= 1'b1;
                pass_o <= 1'b1;
              end
            end else begin
              state       <= ERROR;
              busy_o      <= 1'b0;
              error_o     <= 1'b1;
              err_index_o <= index;
              err_char_o  <= digit_i;
            end
          end else if (wdog == WDOG_LAST) begin
            state       <= ERROR;
            busy_o      <= 1'b0;
            error_o     <= 1'b1;
            timeout_o   <= 1'b1;
            err_index_o <= index;
            err_char_o  <= 8'h00;
          end else begin
            wdog <= wdog + 1'b1;
          end
        end
        DONE: begin
          if (digit_valid_i) begin
            state       <= ERROR;
            done_o      <= 1'b0;
            pass_o      <= 1'b0;
            error_o     <= 1'b1;
            err_index_o <= LAST_IDX;
            err_char_o  <= digit_i;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pi_digit_checker.sv
// Bench for pi_digit_checker: directed scenarios plus randomized streams against an event-level model.
module tb_pi_digit_checker;
  localparam int N = 11;
  localparam int T = 1024;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       valid = 1'b0;
  logic [7:0] digit = 8'h00;
  logic       busy, done, pass, error, timeout;
  logic [3:0] err_index, match_count;
  logic [7:0] err_char;
  logic [1:0] dbg_state;

  int errors = 0;
  int checks = 0;

  string pi_str = "31415926535";

  // Reference model: counts matched digits and idle cycles since the last accepted digit.
  int         m_matched;
  int         m_idle;
  bit         m_active, m_done, m_err, m_to;
  int         m_eidx;
  logic [7:0] m_echar;

  pi_digit_checker #(.NUM_DIGITS(N), .TIMEOUT_CYCLES(T)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start_i       (start),
    .digit_valid_i (valid),
    .digit_i       (digit),
    .busy_o        (busy),
    .done_o        (done),
    .pass_o        (pass),
    .error_o       (error),
    .timeout_o     (timeout),
    .err_index_o   (err_index),
    .err_char_o    (err_char),
    .match_count_o (match_count),
    .dbg_state     (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    m_matched = 0; m_idle = 0; m_active = 0; m_done = 0;
    m_err = 0; m_to = 0; m_eidx = 0; m_echar = 8'h00;
  endtask

  task automatic model_fail(int idx, logic [7:0] ch, bit to);
    m_err = 1; m_to = to; m_eidx = idx; m_echar = ch;
    m_active = 0; m_done = 0;
  endtask

  task automatic model_step(bit st, bit v, logic [7:0] d);
    logic [7:0] e;
    if (st) begin
      model_clear();
    end else if (m_err) begin
      // sticky
    end else if (m_done) begin
      if (v) model_fail(N, d, 0);
    end else if (v) begin
      e = pi_str[m_matched];
      if (d == e) begin
        m_matched++;
        m_idle = 0;
        m_active = 1;
        if (m_matched == N) begin
          m_done = 1;
          m_active = 0;
        end
      end else begin
        model_fail(m_matched, d, 0);
      end
    end else if (m_active) begin
      m_idle++;
      if (m_idle == T) model_fail(m_matched, 8'h00, 1);
    end
  endtask

  task automatic check_eq(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(string tag);
    check_eq({tag, ".busy"},  32'(busy),        32'(m_active));
    check_eq({tag, ".done"},  32'(done),        32'(m_done));
    check_eq({tag, ".pass"},  32'(pass),        32'(m_done));
    check_eq({tag, ".error"}, 32'(error),       32'(m_err));
    check_eq({tag, ".tmo"},   32'(timeout),     32'(m_to));
    check_eq({tag, ".eidx"},  32'(err_index),   32'(m_eidx));
    check_eq({tag, ".echar"}, 32'(err_char),    32'(m_echar));
    check_eq({tag, ".count"}, 32'(match_count), 32'(m_matched));
  endtask

  // Drive on the falling edge, let the rising edge sample, check on the next falling edge.
  task automatic step(bit st, bit v, logic [7:0] d, string tag);
    start = st; valid = v; digit = d;
    @(posedge clk);
    if (rst_n) model_step(st, v, d);
    @(negedge clk);
    start = 1'b0; valid = 1'b0; digit = 8'h00;
    check_all(tag);
  endtask

  task automatic idle(int n, string tag);
    for (int i = 0; i < n; i++) step(0, 0, 8'h00, tag);
  endtask

  task automatic send_chars(string s, int max_gap, string tag);
    for (int i = 0; i < s.len(); i++) begin
      step(0, 1, s[i], tag);
      idle($urandom_range(0, max_gap), tag);
    end
  endtask

  task automatic rearm();
    step(1, 0, 8'h00, "rearm");
  endtask

  initial begin
    model_clear();
    repeat (3) @(negedge clk);
    check_all("reset");
    rst_n = 1'b1;
    idle(3, "idle_noop");

    send_chars("31415926535", 6, "full");
    check_eq("full_done", 32'(done), 32'd1);

    rearm();
    send_chars("3141", 3, "mism");
    step(0, 1, 8'h36, "mism6");
    check_eq("mism_eidx", 32'(err_index), 32'd4);
    send_chars("59", 2, "sticky");

    rearm();
    send_chars("31", 0, "tmo");
    idle(T, "tmo_wait");
    check_eq("tmo_flag", 32'(timeout), 32'd1);
    check_eq("tmo_eidx", 32'(err_index), 32'd2);

    // Strobe on the final watchdog cycle is still accepted.
    rearm();
    send_chars("3", 0, "edge");
    idle(T - 1, "edge_wait");
    send_chars("1415926535", 1, "edge_rest");
    check_eq("edge_done", 32'(done), 32'd1);

    step(0, 1, 8'h3F, "overrun");
    check_eq("overrun_eidx", 32'(err_index), 32'd11);

    rearm();
    step(0, 1, 8'h31, "bad_first");
    rearm();
    send_chars("314", 2, "collide_pre");
    step(1, 1, 8'h33, "collide");
    send_chars("31415926535", 2, "after_collide");
    check_eq("collide_done", 32'(done), 32'd1);

    rearm();
    send_chars("31415", 2, "pre_rst");
    #2 rst_n = 1'b0;
    #1 model_clear();
    check_all("async_rst");
    @(negedge clk);
    check_all("in_rst");
    rst_n = 1'b1;
    send_chars("31415926535", 3, "post_rst");
    check_eq("post_rst_pass", 32'(pass), 32'd1);

    for (int r = 0; r < 40; r++) begin
      rearm();
      for (int k = 0; k < 13; k++) begin
        logic [7:0] ch;
        if (m_matched < N && $urandom_range(0, 9) < 8) ch = pi_str[m_matched];
        else ch = 8'($urandom_range(32, 126));
        step(0, 1, ch, "rnd");
        idle($urandom_range(0, 4), "rnd_gap");
        if ($urandom_range(0, 29) == 0) step(1, $urandom_range(0, 1), ch, "rnd_start");
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
